// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES pad and presents a registered active-low button word.
// Define NES_PAD_DEBOUNCE_EN to commit only after two identical consecutive polls.
module nes_pad_reader #(
    parameter int LATCH_CYCLES = 144,
    parameter int HALF_CYCLES  = 72,
    parameter int POLL_CYCLES  = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data,
    output logic       latch,
    output logic       ctrl_clk,
    output logic [7:0] buttons,
    output logic       update
);
    localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int PL_W   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_CYCLES - 1);
    localparam logic [PL_W-1:0] POLL_LAST  = PL_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_COMMIT
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [PH_W-1:0] r_phase;
    logic [PL_W-1:0] r_poll;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_latch;
    logic            r_ctrl_clk;
    logic [7:0]      r_buttons;
    logic            r_update;
`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0]      r_prev;
`endif

    logic w_bit;
    assign w_bit = r_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            // Reset parks in IDLE at the end of a poll period so the
            // very first released edge enters LATCH.
            r_state    <= S_IDLE;
            r_poll     <= POLL_LAST;
            r_phase    <= '0;
            r_bit      <= 3'd0;
            r_shift    <= 8'hFF;
            r_latch    <= 1'b0;
            r_ctrl_clk <= 1'b0;
            r_buttons  <= 8'hFF;
            r_update   <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
            r_prev     <= 8'hFF;
`endif
        end else begin
            r_sync   <= {r_sync[0], data};
            r_poll   <= r_poll + 1'b1;
            r_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_poll == POLL_LAST) begin
                        r_state <= S_LATCH;
                        r_poll  <= '0;
                        r_phase <= '0;
                        r_bit   <= 3'd0;
                        r_latch <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_phase == LATCH_LAST) begin
                        r_state <= S_LOW;
                        r_phase <= '0;
                        r_latch <= 1'b0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_phase == HALF_LAST) begin
                        r_shift <= {r_shift[6:0], w_bit};
                        r_phase <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_bit      <= r_bit + 1'b1;
                            r_state    <= S_HIGH;
                            r_ctrl_clk <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_phase == HALF_LAST) begin
                        r_state    <= S_LOW;
                        r_phase    <= '0;
                        r_ctrl_clk <= 1'b0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_COMMIT: begin
`ifdef NES_PAD_DEBOUNCE_EN
                    r_prev <= r_shift;
                    if (r_shift == r_prev) begin
                        r_buttons <= r_shift;
                        r_update  <= 1'b1;
                    end
`else
                    r_buttons <= r_shift;
                    r_update  <= 1'b1;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign latch    = r_latch;
    assign ctrl_clk = r_ctrl_clk;
    assign buttons  = r_buttons;
    assign update   = r_update;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: pad-model bench with a scoreboard of committed button words.
// Main instance uses short timing; a second instance checks default-parameter widths.
module tb_nes_pad_reader;
    localparam int LAT  = 4;
    localparam int HALF = 2;
    localparam int POLL = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data;
    logic       latch;
    logic       ctrl_clk;
    logic [7:0] buttons;
    logic       update;

    logic       rst2_n = 1'b0;
    logic       latch2;
    logic       ctrl2;
    logic [7:0] buttons2;
    logic       update2;

    logic [7:0] pad = 8'hFF;
    logic [7:0] sr = 8'hFF;
    logic       force0 = 1'b1;
    logic [7:0] prev_raw = 8'hFF;
    logic [7:0] sb[$];

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rise = -1;

    nes_pad_reader #(
        .LATCH_CYCLES(LAT),
        .HALF_CYCLES (HALF),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .latch   (latch),
        .ctrl_clk(ctrl_clk),
        .buttons (buttons),
        .update  (update)
    );

    nes_pad_reader dut_def (
        .clk     (clk),
        .rst_n   (rst2_n),
        .data    (1'b1),
        .latch   (latch2),
        .ctrl_clk(ctrl2),
        .buttons (buttons2),
        .update  (update2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 4021-style pad: parallel load on latch, shift on ctrl_clk rise.
    always @(posedge latch or posedge ctrl_clk) begin
        if (latch) sr <= pad;
        else       sr <= {sr[6:0], 1'b1};
    end

    assign data = force0 ? 1'b0 : sr[7];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_latch(input string tag);
        int n;
        n = 0;
        while (latch !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, latch, 1);
    endtask

    task automatic frame(input logic [7:0] w);
        int lat_w, rises, overlap, bad_ck, bad_btn, nup, up_k, exp_up;
        logic pck, e_ck;
        logic [7:0] pbtn;
        lat_w = 0; rises = 0; overlap = 0; bad_ck = 0;
        bad_btn = 0; nup = 0; up_k = -1; exp_up = 0;
        pad = w;
`ifdef NES_PAD_DEBOUNCE_EN
        if (w == prev_raw) begin
            sb.push_back(w);
            exp_up = 1;
        end
        prev_raw = w;
`else
        sb.push_back(w);
        exp_up = 1;
`endif
        wait_latch("latch_rise");
        if (last_rise >= 0) check("latch_period", cyc - last_rise, POLL);
        last_rise = cyc;
        pck = 1'b0;
        pbtn = buttons;
        for (int k = 0; k < 99; k++) begin
            if (k > 0) @(negedge clk);
            if (latch === 1'b1) lat_w++;
            if (latch === 1'b1 && ctrl_clk === 1'b1) overlap++;
            if (ctrl_clk === 1'b1 && pck === 1'b0) rises++;
            pck = ctrl_clk;
            e_ck = (((k - 4) / 2) % 2) == 1;
            if (k >= 4 && k <= 33 && ctrl_clk !== e_ck) bad_ck++;
            if (update === 1'b1) begin
                nup++;
                up_k = k;
                if (sb.size() > 0) check("buttons", buttons, sb.pop_front());
                else check("unexpected_update", update, 0);
            end
            if (update !== 1'b1 && buttons !== pbtn) bad_btn++;
            pbtn = buttons;
        end
        check("latch_width", lat_w, LAT);
        check("ctrl_rises", rises, 7);
        check("latch_ctrl_overlap", overlap, 0);
        check("ctrl_phase_errs", bad_ck, 0);
        check("update_count", nup, exp_up);
        if (exp_up == 1) check("update_latency", up_k, LAT + 15 * HALF + 1);
        check("buttons_stable", bad_btn, 0);
    endtask

    initial begin
        int n, w, t0;

        rst_n = 1'b0;
        force0 = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_buttons", buttons, 8'hFF);
        check("rst_latch", latch, 0);
        check("rst_ctrl_clk", ctrl_clk, 0);
        check("rst_update", update, 0);
        pad = 8'hFF;
        rst_n = 1'b1;
        force0 = 1'b0;
        @(negedge clk);
        check("first_edge_latch", latch, 1);

        frame(8'hFF);
        frame(8'hFE);
        frame(8'hFE);
        frame(8'hF7);
        frame(8'hF7);
        frame(8'hFF);
        frame(8'hFF);

        pad = 8'hFE;
        wait_latch("mf_latch_rise");
        repeat (18) @(negedge clk);
        check("mf_in_high4", ctrl_clk, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mf_buttons", buttons, 8'hFF);
        check("mf_update", update, 0);
        check("mf_latch", latch, 0);
        check("mf_ctrl_clk", ctrl_clk, 0);
        rst_n = 1'b1;
        prev_raw = 8'hFF;
        last_rise = -1;
        @(negedge clk);
        check("mf_relatch", latch, 1);
        frame(8'hFE);
        frame(8'hFE);
        check("mf_final_buttons", buttons, 8'hFE);
        check("sb_empty", sb.size(), 0);

        rst2_n = 1'b1;
        n = 0;
        while (latch2 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("def_latch_rise", latch2, 1);
        t0 = cyc;
        w = 0;
        while (latch2 === 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("def_latch_width", w, 144);
        w = 0;
        while (ctrl2 === 1'b0 && latch2 === 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("def_low_width", w, 72);
        w = 0;
        while (ctrl2 === 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("def_high_width", w, 72);
        n = 0;
        while (update2 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("def_update_latency", cyc - t0, 144 + 15 * 72 + 1);
        check("def_buttons", buttons2, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Serial reader for the NES game controller. Drives the pad's `latch` and `ctrl_clk` lines, shifts in the 8 button bits from `data` at a fixed poll rate, and presents them as a registered, active-low `buttons[7:0]` word. The word goes to the top-level movement logic, where bit 0 moves right, bit 1 left, bit 2 down and bit 3 up. The block sits between the board pins and the frame-rate position update, and replaces the ad-hoc controller module.

## Interface
Parameters:
- `LATCH_CYCLES`, default 144: latch high width in `clk` cycles (12 µs at 12 MHz).
- `HALF_CYCLES`, default 72: width of each `ctrl_clk` low or high phase (6 µs).
- `POLL_CYCLES`, default 200000: cycles from one latch rise to the next (~60 Hz). Must be greater than `LATCH_CYCLES + 15*HALF_CYCLES + 2`.

Ports:
- `clk`  in  1  system clock (`clk_in` domain, 12 MHz).
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `data`  in  1  pad serial output. Asynchronous to `clk`; 0 = pressed.
- `latch`  out  1  pad latch strobe, active high.
- `ctrl_clk`  out  1  pad shift clock.
- `buttons`  out  8  active-low state: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right.
- `update`  out  1  one-cycle pulse on the cycle `buttons` takes a committed value.

## Operation
- `data` passes through a 2-flop synchronizer. All sampling uses the synchronized bit.
- FSM states and transitions:
  - IDLE: wait until the poll counter reaches `POLL_CYCLES-1`, then go to LATCH.
  - LATCH: `latch`=1 for `LATCH_CYCLES` cycles, then go to LOW.
  - LOW: `ctrl_clk`=0 for `HALF_CYCLES` cycles. On the last cycle, shift the synchronized `data` into the shift register, MSB first.
    - If fewer than 8 bits have been taken, go to HIGH.
    - Otherwise go to COMMIT.
  - HIGH: `ctrl_clk`=1 for `HALF_CYCLES` cycles, then go to LOW.
  - COMMIT: one cycle. Load `buttons` from the shift register, pulse `update`, go to IDLE.
- A frame has 8 LOW phases and 7 HIGH phases. The first bit (A) is valid straight after the latch falls.
- The poll counter is free-running. It clears to 0 on the cycle LATCH is entered, so the latch-to-latch period is exactly `POLL_CYCLES`.
- The bit counter is 3 bits and clears on LATCH entry.
- Phase counter width is `$clog2` of the largest phase parameter. The poll counter width is `$clog2(POLL_CYCLES)`.
- `latch`, `ctrl_clk`, `buttons` and `update` are all registered outputs, with no combinational path from `data`.
- If the pad is disconnected, `data` floats high, which reads as 8'hFF (nothing pressed). No special handling.

## Timing
- Reset values: `latch`=0, `ctrl_clk`=0, `buttons`=8'hFF, `update`=0. The FSM resets into LATCH entry.
- `rst_n` low at any point, including mid-frame, restores all reset values on the next edge. The partially shifted word is discarded.
- First edge with `rst_n`=1: `latch` rises. The FSM never emits a short latch.
- `latch` is high for exactly `LATCH_CYCLES` cycles. Each `ctrl_clk` phase lasts exactly `HALF_CYCLES` cycles.
- `latch` and `ctrl_clk` are never high together.
- Latency from latch rise to `update`: `LATCH_CYCLES + 15*HALF_CYCLES + 1` cycles.
- `update` pulses exactly once per frame (without debounce). `buttons` is stable between updates.
- A `data` edge less than 3 cycles before a sample point may be missed. This is acceptable at the default timing.

## Configuration
- `NES_PAD_DEBOUNCE_EN` defined:
  - The block keeps the previous frame's raw word.
  - COMMIT loads `buttons` and pulses `update` only when the new word equals the previous raw word.
  - Otherwise it stores the raw word and returns to IDLE without touching `buttons` or `update`.
  - A change takes two consecutive identical polls to appear. The previous raw word resets to 8'hFF.
- Not defined: every frame commits unconditionally.

## Test plan
Use `LATCH_CYCLES`=4, `HALF_CYCLES`=2 and `POLL_CYCLES`=100 unless noted.
- **Reset:** hold `rst_n`=0 for 5 cycles with `data`=0 → `buttons`=8'hFF, `latch`=0, `ctrl_clk`=0, `update`=0. `latch` rises on the first edge after release.
- **Protocol timing:** pad model with all buttons released → `latch` high 4 cycles, then 7 `ctrl_clk` pulses each 2 high / 2 low. `update` fires at cycle 35 after the latch rise. The next latch rises at cycle 100.
- **Data mapping:** pad model shifting A, B, Sel, Start, Up, Down, Left, Right = 1,1,1,1,1,1,1,0 (Right pressed) → `buttons`=8'hFE. With only Up pressed → 8'hF7.
- **Reset mid-frame:** assert `rst_n`=0 during the 4th HIGH phase with Right pressed → `buttons` stays 8'hFF. A full new frame follows release, and then `buttons`=8'hFE.
- **Debounce (macro on):** Right pressed in one frame, released in the next → no `update`, `buttons`=8'hFF. Right pressed in two consecutive frames → `update` on the second frame, `buttons`=8'hFE.
- **Default parameters:** run 2 frames → latch width 144, phase width 72, latch period 200000 cycles.
